spi_shared_master: RTL
======================

Name: spi_shared_master

Overview:
- Sequencer and arbiter for the shared board SPI bus (MOSI/SCLK/MISO, active-low per-slave enables) that serves the AD9361 (slave 0) and the ADF4001 reference PLL (slave 1).
- Two independent requesters issue complete transactions:
  - req0: host settings-bus SPI core.
  - req1: local calibration/lock-maintenance engine.
- The block grants requesters round-robin and serialises the transfer MSB-first, SPI mode 0.
- It returns readback data to the requester that was granted.

Parameters:
- NUM_SLAVES, 8, width of sen; slave-select indices at or above this value address no device.
- CLK_DIV, 4, SCLK half-period in clk cycles (≥1).

Ports:
- clk  in  1  single clock; all logic in this domain.
- reset  in  1  asynchronous, active-high.
- req0_valid  in  1  requester 0 transaction request.
- req0_ready  out  1  requester 0 accept.
- req0_sel  in  3  slave index.
- req0_len  in  6  bit count; 0 and values above 32 mean 32.
- req0_data  in  32  write data, left-justified; bit 31 is sent first.
- req1_valid, req1_ready, req1_sel, req1_len, req1_data: same directions, widths and meanings for requester 1.
- rsp0_valid  out  1  one-cycle completion pulse to requester 0.
- rsp0_data  out  32  readback, right-justified; bits above len are zero.
- rsp1_valid, rsp1_data: same as rsp0_* for requester 1.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  SPI data out.
- sen  out  NUM_SLAVES  active-low enables; idle all ones.
- miso  in  1  SPI data in.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - sen = all ones; sclk = 0; mosi = 0; busy = 0.
  - req*_ready = 0; rsp*_valid = 0; rsp*_data = 0.
  - FSM = IDLE; last_grant = 1, so requester 0 wins the first tie.
- Arbitration (IDLE only):
  - grant = the valid requester not equal to last_grant if both are valid; otherwise the single valid one.
  - reqN_ready = (state==IDLE) && grant==N; combinational from valid.
  - Accept = valid && ready. On accept, latch sel, effective len, data and grant; update last_grant; go to SETUP.
  - Requests arriving while busy wait; no ready is issued.
- FSM, with D = CLK_DIV and the half-period counter reloaded on every state entry:
  - SETUP (D cycles): sen[sel] = 0, sclk = 0, mosi = shreg[31]. Then go to HIGH.
  - HIGH (D cycles): sclk = 1. Sample miso into rxreg LSB on the first HIGH cycle (shift left). Then go to LOW.
  - LOW (D cycles): sclk = 0. On entry, shift shreg left and drive mosi = new shreg[31]. Decrement the bit counter. If bits remain, go to HIGH; else go to HOLD.
  - HOLD (D cycles): sen held low, sclk = 0. Then go to DONE.
  - DONE (1 cycle): sen = all ones, mosi = 0. rspN_valid = 1 for the latched grant only; rspN_data = rxreg masked to len. Then go to IDLE.
- Timing, with accept at cycle t0:
  - sen is low for cycles t0+1 through t0+(2·len+2)·D.
  - The rsp pulse occurs at t0+1+(2·len+2)·D.
  - IDLE follows, so sen is high for at least 2 cycles between back-to-back transfers.
- rspN_data holds its value until the next rspN pulse.
- Out-of-range slave (sel ≥ NUM_SLAVES): full timing executes; all sen stay high; sclk and mosi toggle as normal; rsp data = sampled miso.
- Reset mid-transfer: outputs go to reset values immediately (asynchronous). No rsp is issued, the transaction is dropped and last_grant returns to 1.
- No other simultaneity: only IDLE accepts requests and a single transaction is in flight.

Test Plan:
1. CLK_DIV=2; req0 sel=0, len=24, data=0x8A_5C_3F00; miso=0 → sen[0] low for exactly 100 cycles; 24 rising sclk edges; mosi bits on rising edges = 0x8A5C3F MSB-first; rsp0_valid at t0+101 with data 0x000000.
2. req1 sel=1, len=8, data=0xC3000000; bench drives miso pattern 0xA5 mode-0 → rsp1_data = 0x000000A5; rsp0_valid never pulses; sen[1] only asserted.
3. req0 and req1 valid continuously from reset → grants alternate 0,1,0,1; each rsp goes only to its own requester; sen high ≥2 cycles between transfers.
4. len=0, data=0xFFFF0001 → 32 sclk rising edges; miso looped from mosi → rsp_data = 0xFFFF0001.
5. Assert reset at the 10th sclk rising edge → same cycle: sen=0xFF, sclk=0, busy=0; no rsp pulse; next request is accepted normally with requester 0 first.
6. sel=7 with NUM_SLAVES=2 → sen stays 2'b11; 2·len sclk edges; rsp pulses at the normal cycle.

Source files
------------

// File: rtl/spi_shared_master.sv
// Round-robin arbiter and SPI mode-0 sequencer letting two requesters share one SPI bus.
// Latency: rsp pulse (2*len+2)*CLK_DIV+1 cycles after accept; sen low for the first (2*len+2)*CLK_DIV of them.
// Backpressure: ready only in IDLE toward the granted requester; other requests hold valid and wait.
module spi_shared_master #(
  parameter int NUM_SLAVES = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_sel,
  input  logic [5:0]            req0_len,
  input  logic [31:0]           req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_sel,
  input  logic [5:0]            req1_len,
  input  logic [31:0]           req1_data,
  output logic                  rsp0_valid,
  output logic [31:0]           rsp0_data,
  output logic                  rsp1_valid,
  output logic [31:0]           rsp1_data,
  output logic                  sclk,
  output logic                  mosi,
  output logic [NUM_SLAVES-1:0] sen,
  input  logic                  miso,
  output logic                  busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     bits_q, bits_d;
  logic [5:0]     len_q, len_d;
  logic [2:0]     sel_q, sel_d;
  logic           gnt_q, gnt_d;
  logic           last_q, last_d;
  logic [31:0]    shreg_q, shreg_d;
  logic [31:0]    rxreg_q, rxreg_d;
  logic [31:0]    rsp0_data_q, rsp0_data_d;
  logic [31:0]    rsp1_data_q, rsp1_data_d;

  logic grant;
  logic active;
  logic cnt_done;

  // Zero and anything above 32 both mean a full 32-bit transfer.
  function automatic logic [5:0] eff_len(input logic [5:0] l);
    return ((l == 6'd0) || (l > 6'd32)) ? 6'd32 : l;
  endfunction

  function automatic logic [31:0] len_mask(input logic [5:0] n);
    return (n >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // Arbitration: alternate on contention, otherwise serve whoever is valid.
  always_comb begin
    grant      = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (!req0_valid)         grant = 1'b1;
    req0_ready = (state_q == IDLE) && req0_valid && (grant == 1'b0);
    req1_ready = (state_q == IDLE) && req1_valid && (grant == 1'b1);
  end

  // Bus outputs decode straight from state so an asynchronous reset releases the bus at once.
  always_comb begin
    active     = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW) || (state_q == HOLD);
    busy       = (state_q != IDLE);
    sclk       = (state_q == HIGH);
    mosi       = active ? shreg_q[31] : 1'b0;
    rsp0_valid = (state_q == DONE) && (gnt_q == 1'b0);
    rsp1_valid = (state_q == DONE) && (gnt_q == 1'b1);
    rsp0_data  = rsp0_data_q;
    rsp1_data  = rsp1_data_q;
    sen        = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (active && (int'(sel_q) == i)) sen[i] = 1'b0;
    end
  end

  assign cnt_done = (cnt_q == '0);

  // Next-state: every state lasts CLK_DIV cycles except DONE; the counter reloads on each entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    len_d       = len_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    shreg_d     = shreg_q;
    rxreg_d     = rxreg_q;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          gnt_d   = grant;
          last_d  = grant;
          sel_d   = grant ? req1_sel : req0_sel;
          len_d   = eff_len(grant ? req1_len : req0_len);
          bits_d  = eff_len(grant ? req1_len : req0_len);
          shreg_d = grant ? req1_data : req0_data;
          rxreg_d = '0;
          cnt_d   = CNT_RELOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          cnt_d   = CNT_RELOAD;
          state_d = HIGH;
        end else cnt_d = cnt_q - CW'(1);
      end
      HIGH: begin
        // Slave drove its bit on the previous falling edge; take it on the first high cycle.
        if (cnt_q == CNT_RELOAD) rxreg_d = {rxreg_q[30:0], miso};
        if (cnt_done) begin
          cnt_d   = CNT_RELOAD;
          shreg_d = {shreg_q[30:0], 1'b0};
          bits_d  = bits_q - 6'd1;
          state_d = LOW;
        end else cnt_d = cnt_q - CW'(1);
      end
      LOW: begin
        if (cnt_done) begin
          cnt_d   = CNT_RELOAD;
          state_d = (bits_q != 6'd0) ? HIGH : HOLD;
        end else cnt_d = cnt_q - CW'(1);
      end
      HOLD: begin
        if (cnt_done) begin
          if (gnt_q) rsp1_data_d = rxreg_q & len_mask(len_q);
          else       rsp0_data_d = rxreg_q & len_mask(len_q);
          state_d = DONE;
        end else cnt_d = cnt_q - CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; last grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      len_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      shreg_q     <= '0;
      rxreg_q     <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      len_q       <= len_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      shreg_q     <= shreg_d;
      rxreg_q     <= rxreg_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end

endmodule
